ib_mul_sched: RTL
=================

Name: ib_mul_sched

Overview:
- Shares one digit-serial 8x8 unsigned multiplier between N requesters, with round-robin arbitration.
- Each accepted job is computed over 4 cycles, one 2-bit digit of i_b per cycle: a 8x2 partial product is shifted and accumulated into a 16-bit result.
- Trades the area of a full combinational 8x8 array for fixed latency and a per-job handshake.
- Sits between multiple arithmetic clients and a single multiplier resource in the ib_mul family.

Parameters:
- N, 4, number of requesters (2..8).
- IDW, 2, requester id width; must equal clog2(N).

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  reset: asynchronous, active-high.
- i_req  input  N  per-requester job request; held with operands until acked.
- i_a  input  N*8  operand A per requester; slice k = i_a[8k+7:8k].
- i_b  input  N*8  operand B per requester; same slicing.
- o_ack  output  N  one-hot, single-cycle pulse: job of that requester captured.
- o_busy  output  1  high while a job is in RUN.
- o_valid  output  1  single-cycle pulse: o_c/o_id hold a finished result.
- o_id  output  IDW  id of the requester whose result is on o_c.
- o_c  output  16  product A*B, unsigned.

Behaviour:
- Reset:
  - State IDLE; cnt=0; acc=0.
  - o_ack=0, o_busy=0, o_valid=0, o_id=0, o_c=0.
  - Round-robin pointer ptr=N-1, so requester 0 wins first.
  - Reset is async assert; release is used synchronously with i_clk.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- State IDLE:
  - If i_req==0, stay in IDLE.
  - Otherwise pick the first set bit searching ptr+1, ptr+2, ... with wrap modulo N.
  - On that edge: latch a_r, b_r, id_r; set ptr=id; acc=0; cnt=0; o_ack[id]=1; go to RUN.
- State RUN:
  - Each edge: acc += ({2'b0,a_r} * b_r[2cnt+1:2cnt]) << 2cnt, with a 10-bit partial product zero-extended to 16 bits; cnt++.
  - o_ack clears after its single cycle.
  - On the edge where cnt==3: o_c = final acc; o_id = id_r; o_valid = 1; go to IDLE.
- Timing:
  - If the accept edge is E0, o_ack is high in the cycle after E0.
  - o_valid is high in the cycle after E4, i.e. exactly 4 cycles after o_ack.
  - o_valid and o_c are updated in the same cycle.
- o_busy is high from E0 to E4, so it is high while in RUN.
- Throughput: at most one job per 5 cycles. A new accept can happen at E5, while o_valid from the previous job is still high.
- o_c and o_id hold their value after o_valid falls, until the next completion.
- Width: the maximum product is 255*255 = 65025, so the 16-bit accumulator never overflows and no saturation is needed.
- i_req and operands are ignored outside IDLE. A requester that drops i_req before o_ack simply loses its turn; there is no penalty.
- Requesters must drop or renew i_req in the cycle o_ack is seen. The 4-cycle RUN guarantees the stale request is gone before the next IDLE.
- Operand changes after the accept edge have no effect, because operands are latched.
- Reset during RUN: the job is discarded and no o_valid is produced. All state returns to reset values, including ptr.
- A requester re-requesting immediately after its own grant is served last among the active requesters (fairness).

Decomposition:
- Package ib_mul_pkg:
  - DIGIT_W=2, DIGITS=4, A_W=8, C_W=16.
  - State encoding: IDLE=1'b0, RUN=1'b1.
  - cnt width clog2(DIGITS).
- Sub-module ib_mul_rr_pick:
  - Combinational round-robin picker.
  - Inputs: req[N], ptr[IDW]. Outputs: any, gnt_onehot[N], gnt_id[IDW].
  - Instantiated once.
- The digit-serial multiply-accumulate stays inline in ib_mul_sched.

Test Plan:
- After reset, req=0001, a0=0xFF, b0=0xFF -> o_ack=0001 one cycle; 4 cycles later o_valid=1, o_id=0, o_c=0xFE01; o_busy high for 4 cycles.
- req=1111 held continuously, ak=k+3, bk=k+5 -> acks in order 0,1,2,3,0 spaced 5 cycles; results 15, 24, 35, 48 with matching o_id.
- req1 and req3 asserted continuously, after a grant to 1 -> next grants 3, 1, 3; requester 0 rises later and is granted before 1 when ptr=3.
- Edge values: a=0x00, b=0xAB -> 0x0000; a=0x80, b=0x80 -> 0x4000; a=0x01, b=0xFF -> 0x00FF. Operands change after o_ack -> result unchanged.
- i_rst pulsed during the 2nd RUN cycle -> no o_valid, all outputs 0, ptr reset; the next request from 2 with 0 also pending grants 0 first.
- 10k random jobs with random i_req patterns -> every o_c equals a*b of the latched operands; each ack has exactly one o_valid with matching o_id; no requester starves beyond N grants.

Source files
------------

// File: rtl/ib_mul_pkg.sv
// Shared constants and state encoding for the digit-serial multiplier scheduler.
package ib_mul_pkg;
    localparam int DIGIT_W = 2;
    localparam int DIGITS  = 4;
    localparam int A_W     = 8;
    localparam int C_W     = 16;
    localparam int CNT_W   = $clog2(DIGITS);
    localparam int PP_W    = A_W + DIGIT_W;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;
endpackage

// File: rtl/ib_mul_rr_pick.sv
// Combinational round-robin picker: first set request after ptr, wrapping modulo N.
module ib_mul_rr_pick #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] ptr_i,
    output logic           any_o,
    output logic [N-1:0]   gnt_onehot_o,
    output logic [IDW-1:0] gnt_id_o
);
    int idx;

    always_comb begin
        any_o        = 1'b0;
        gnt_onehot_o = '0;
        gnt_id_o     = '0;
        idx          = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr_i) + k) % N;
            if (!any_o && req_i[idx]) begin
                any_o             = 1'b1;
                gnt_onehot_o[idx] = 1'b1;
                gnt_id_o          = IDW'(idx);
            end
        end
    end
endmodule

// File: rtl/ib_mul_sched.sv
// One 8x8 digit-serial multiplier shared round-robin between N requesters;
// each job takes 4 cycles (2 bits of B per cycle) and all outputs are registered.
module ib_mul_sched
    import ib_mul_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N-1:0]     i_req,
    input  logic [N*A_W-1:0] i_a,
    input  logic [N*A_W-1:0] i_b,
    output logic [N-1:0]     o_ack,
    output logic             o_busy,
    output logic             o_valid,
    output logic [IDW-1:0]   o_id,
    output logic [C_W-1:0]   o_c
);
    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [C_W-1:0]     acc_q;
    logic [C_W-1:0]     acc_d;
    logic [A_W-1:0]     a_q;
    logic [A_W-1:0]     b_q;
    logic [IDW-1:0]     id_q;
    logic [IDW-1:0]     ptr_q;
    logic [N-1:0]       ack_q;
    logic               busy_q;
    logic               valid_q;
    logic [IDW-1:0]     oid_q;
    logic [C_W-1:0]     c_q;

    logic               pick_any;
    logic [N-1:0]       pick_onehot;
    logic [IDW-1:0]     pick_id;
    logic [A_W-1:0]     pick_a;
    logic [A_W-1:0]     pick_b;
    logic [DIGIT_W-1:0] digit;
    logic [PP_W-1:0]    pp;

    ib_mul_rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req_i        (i_req),
        .ptr_i        (ptr_q),
        .any_o        (pick_any),
        .gnt_onehot_o (pick_onehot),
        .gnt_id_o     (pick_id)
    );

    always_comb begin
        pick_a = i_a[A_W*int'(pick_id) +: A_W];
        pick_b = i_b[A_W*int'(pick_id) +: A_W];
    end

    // Partial product of A by the current 2-bit digit of B, placed at its digit weight.
    always_comb begin
        digit = b_q[DIGIT_W*int'(cnt_q) +: DIGIT_W];
        pp    = {{DIGIT_W{1'b0}}, a_q} * PP_W'(digit);
        acc_d = acc_q + (C_W'(pp) << (DIGIT_W*int'(cnt_q)));
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            id_q    <= '0;
            ptr_q   <= IDW'(N-1);
            ack_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            oid_q   <= '0;
            c_q     <= '0;
        end else begin
            ack_q   <= '0;
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        a_q     <= pick_a;
                        b_q     <= pick_b;
                        id_q    <= pick_id;
                        ptr_q   <= pick_id;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        ack_q   <= pick_onehot;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DIGITS-1)) begin
                        c_q     <= acc_d;
                        oid_q   <= id_q;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_ack   = ack_q;
    assign o_busy  = busy_q;
    assign o_valid = valid_q;
    assign o_id    = oid_q;
    assign o_c     = c_q;
endmodule
